// File: rtl/sdram_cmd_dispatcher_if.sv
// Command-port bundle between the processor/controller side and the SDRAM
// command dispatcher.
interface sdram_cmd_dispatcher_if #(
    parameter int PADD_SIZE = 24
);
    logic                 cmd_valid;
    logic [2:0]           cmd;
    logic [PADD_SIZE-1:0] paddr;
    logic                 cmd_ready;
    logic                 cmdack;
    logic                 nop;
    logic                 reada;
    logic                 writea;
    logic                 refresh;
    logic                 precharge;
    logic                 load_mod;
    logic                 load_time;
    logic                 load_rfcnt;
    logic [PADD_SIZE-1:0] caddr;
    logic                 busy;
    logic                 overflow;
    logic                 ack_timeout;

    modport master (
        output cmd_valid, cmd, paddr, cmdack,
        input  cmd_ready, nop, reada, writea, refresh, precharge,
               load_mod, load_time, load_rfcnt, caddr, busy, overflow, ack_timeout
    );

    modport slave (
        input  cmd_valid, cmd, paddr, cmdack,
        output cmd_ready, nop, reada, writea, refresh, precharge,
               load_mod, load_time, load_rfcnt, caddr, busy, overflow, ack_timeout
    );
endinterface

// File: rtl/sdram_cmd_dispatcher.sv
// SDRAM command front end: buffers {cmd, paddr} in a FIFO, issues each as a
// held one-hot strobe until cmdack, with a one-cycle gap and optional timeout.
module sdram_cmd_dispatcher #(
    parameter int PADD_SIZE   = 24,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 0
) (
    input  logic                    clk0,
    input  logic                    reset,
    sdram_cmd_dispatcher_if.slave   bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam bit TO_EN = (ACK_TIMEOUT > 0);
    localparam logic [CW-1:0] T_MAX = CW'(ACK_TIMEOUT);
    localparam logic [AW:0]   DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    typedef struct packed {
        logic [2:0]           cmd;
        logic [PADD_SIZE-1:0] addr;
    } entry_t;

    state_t               state, state_d;
    logic [7:0]           strobe_q, strobe_d;
    logic [PADD_SIZE-1:0] caddr_q, caddr_d;
    logic [CW-1:0]        wait_cnt, cnt_d;
    logic                 overflow_q, timeout_q, timeout_hit;

    entry_t               mem [FIFO_DEPTH];
    entry_t               head;
    logic [AW-1:0]        rd_ptr, wr_ptr;
    logic [AW:0]          count;
    logic                 empty, full, push, pop, ready;

    assign empty = (count == '0);
    assign full  = (count == DEPTH);
    assign head  = mem[rd_ptr];
    // A pop in the same cycle frees a slot, so a push at full is still taken.
    assign ready = !full || pop;
    assign push  = bus.cmd_valid && ready;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d     = state;
        strobe_d    = strobe_q;
        caddr_d     = caddr_q;
        cnt_d       = wait_cnt;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE, GAP: begin
                strobe_d = '0;
                state_d  = IDLE;
                if (!empty) begin
                    pop      = 1'b1;
                    strobe_d = 8'b1 << head.cmd;
                    caddr_d  = head.addr;
                    cnt_d    = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // A NOP never waits for cmdack; it is a single-cycle pulse.
                if (strobe_q[0] || bus.cmdack) begin
                    strobe_d = '0;
                    state_d  = GAP;
                end else if (TO_EN && wait_cnt == T_MAX) begin
                    strobe_d    = '0;
                    timeout_hit = 1'b1;
                    state_d     = GAP;
                end else if (wait_cnt != T_MAX) begin
                    cnt_d = wait_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk0) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= IDLE;
            strobe_q   <= '0;
            caddr_q    <= '0;
            wait_cnt   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state    <= state_d;
            strobe_q <= strobe_d;
            caddr_q  <= caddr_d;
            wait_cnt <= cnt_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (bus.cmd_valid && !ready) overflow_q <= 1'b1;
            if (timeout_hit)             timeout_q  <= 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk0) begin
        if (push) mem[wr_ptr] <= {bus.cmd, bus.paddr};
    end

    assign bus.cmd_ready   = ready;
    assign bus.nop         = strobe_q[0];
    assign bus.reada       = strobe_q[1];
    assign bus.writea      = strobe_q[2];
    assign bus.refresh     = strobe_q[3];
    assign bus.precharge   = strobe_q[4];
    assign bus.load_mod    = strobe_q[5];
    assign bus.load_time   = strobe_q[6];
    assign bus.load_rfcnt  = strobe_q[7];
    assign bus.caddr       = caddr_q;
    assign bus.busy        = (state != IDLE) || !empty;
    assign bus.overflow    = overflow_q;
    assign bus.ack_timeout = timeout_q;

endmodule

// File: tb/tb_sdram_cmd_dispatcher.sv
// Bench for sdram_cmd_dispatcher: two instances (timeout off / ACK_TIMEOUT=8)
// share stimulus; a table, directed corner sequences and a random run vs a model.
module tb_sdram_cmd_dispatcher;

    localparam int PS = 24;
    localparam int DEPTH = 4;

    logic          clk0 = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [2:0]    cmd = '0;
    logic [PS-1:0] paddr = '0;
    logic          cmdack = 1'b0;
    bit            model_on = 1'b0;
    int            total = 0;
    int            bad = 0;

    always #5 clk0 = ~clk0;

    sdram_cmd_dispatcher_if #(.PADD_SIZE(PS)) bus0 ();
    sdram_cmd_dispatcher_if #(.PADD_SIZE(PS)) bus8 ();

    assign bus0.cmd_valid = cmd_valid;
    assign bus0.cmd       = cmd;
    assign bus0.paddr     = paddr;
    assign bus0.cmdack    = cmdack;
    assign bus8.cmd_valid = cmd_valid;
    assign bus8.cmd       = cmd;
    assign bus8.paddr     = paddr;
    assign bus8.cmdack    = cmdack;

    sdram_cmd_dispatcher #(.PADD_SIZE(PS), .FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(0)) dut0 (
        .clk0(clk0), .reset(reset), .bus(bus0.slave));
    sdram_cmd_dispatcher #(.PADD_SIZE(PS), .FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(8)) dut8 (
        .clk0(clk0), .reset(reset), .bus(bus8.slave));

    logic [7:0]    d_strobe [2];
    logic [PS-1:0] d_caddr  [2];
    logic          d_busy   [2];
    logic          d_ready  [2];
    logic          d_ovf    [2];
    logic          d_tmo    [2];

    assign d_strobe[0] = {bus0.load_rfcnt, bus0.load_time, bus0.load_mod, bus0.precharge,
                          bus0.refresh, bus0.writea, bus0.reada, bus0.nop};
    assign d_strobe[1] = {bus8.load_rfcnt, bus8.load_time, bus8.load_mod, bus8.precharge,
                          bus8.refresh, bus8.writea, bus8.reada, bus8.nop};
    assign d_caddr[0] = bus0.caddr;       assign d_caddr[1] = bus8.caddr;
    assign d_busy[0]  = bus0.busy;        assign d_busy[1]  = bus8.busy;
    assign d_ready[0] = bus0.cmd_ready;   assign d_ready[1] = bus8.cmd_ready;
    assign d_ovf[0]   = bus0.overflow;    assign d_ovf[1]   = bus8.overflow;
    assign d_tmo[0]   = bus0.ack_timeout; assign d_tmo[1]   = bus8.ack_timeout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending commands plus the command currently
    // on the strobes (cur < 0: none), how long it has been held, and whether
    // the current cycle is the mandatory gap.
    int            lim [2] = '{0, 8};
    logic [26:0]   mq [2][8];
    int            mh [2], mn [2];
    int            cur [2], held [2];
    bit            gap [2], m_ovf [2], m_tmo [2];
    logic [PS-1:0] m_caddr [2];

    task automatic model_step(input int k);
        bit pop, rdy, done_ok;
        logic [26:0] h;
        if (reset) begin
            cur[k] = -1; held[k] = 0; gap[k] = 0; m_ovf[k] = 0; m_tmo[k] = 0;
            m_caddr[k] = '0; mh[k] = 0; mn[k] = 0;
        end else begin
            pop = (cur[k] < 0) && (mn[k] > 0);
            rdy = (mn[k] < DEPTH) || pop;
            h   = mq[k][mh[k]];
            if (cur[k] >= 0) begin
                done_ok = (cur[k] == 0) || cmdack;
                if (done_ok || (lim[k] > 0 && held[k] == lim[k])) begin
                    if (!done_ok) m_tmo[k] = 1;
                    cur[k] = -1;
                    gap[k] = 1;
                end else begin
                    held[k]++;
                end
            end else if (pop) begin
                cur[k]     = int'(h[26:24]);
                m_caddr[k] = h[23:0];
                held[k]    = 0;
                gap[k]     = 0;
                mh[k]      = (mh[k] + 1) % 8;
                mn[k]--;
            end else begin
                gap[k] = 0;
            end
            if (cmd_valid) begin
                if (rdy) begin
                    mq[k][(mh[k] + mn[k]) % 8] = {cmd, paddr};
                    mn[k]++;
                end else begin
                    m_ovf[k] = 1;
                end
            end
        end
    endtask

    // Inputs are stable between posedge+1 and the next posedge, so at the
    // negedge we compare against the model, then advance it with the inputs
    // the DUT is about to sample.
    always @(negedge clk0) begin
        if (model_on) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("m_strobe[%0d]", k), 32'(d_strobe[k]),
                      (cur[k] >= 0) ? 32'(8'h1 << cur[k]) : 32'h0);
                check($sformatf("m_caddr[%0d]", k), 32'(d_caddr[k]), 32'(m_caddr[k]));
                check($sformatf("m_busy[%0d]", k), 32'(d_busy[k]),
                      32'((cur[k] >= 0) || gap[k] || (mn[k] > 0)));
                check($sformatf("m_ready[%0d]", k), 32'(d_ready[k]),
                      32'((mn[k] < DEPTH) || (cur[k] < 0 && mn[k] > 0)));
                check($sformatf("m_ovf[%0d]", k), 32'(d_ovf[k]), 32'(m_ovf[k]));
                check($sformatf("m_tmo[%0d]", k), 32'(d_tmo[k]), 32'(m_tmo[k]));
            end
        end
        for (int k = 0; k < 2; k++) model_step(k);
    end

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic drive(input bit v, input logic [2:0] c, input logic [PS-1:0] a, input bit ack);
        cmd_valid = v; cmd = c; paddr = a; cmdack = ack;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 3'd0, '0, 0);
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        bit            v;
        logic [2:0]    c;
        logic [PS-1:0] a;
        bit            ack;
        logic [7:0]    strobe;
        logic [PS-1:0] caddr;
        bit            busy;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_cnt;
        int n;

        // Single reada acked on its second cycle, then three back-to-back
        // commands each acked in their first ISSUE cycle.
        tbl[0]  = '{1, 3'd1, 24'h123456, 0, 8'h00, 24'h000000, 1};
        tbl[1]  = '{0, 3'd0, 24'h0,      0, 8'h02, 24'h123456, 1};
        tbl[2]  = '{0, 3'd0, 24'h0,      0, 8'h02, 24'h123456, 1};
        tbl[3]  = '{0, 3'd0, 24'h0,      1, 8'h00, 24'h123456, 1};
        tbl[4]  = '{0, 3'd0, 24'h0,      0, 8'h00, 24'h123456, 0};
        tbl[5]  = '{1, 3'd2, 24'hA00001, 0, 8'h00, 24'h123456, 1};
        tbl[6]  = '{1, 3'd3, 24'hA00002, 0, 8'h04, 24'hA00001, 1};
        tbl[7]  = '{1, 3'd4, 24'hA00003, 1, 8'h00, 24'hA00001, 1};
        tbl[8]  = '{0, 3'd0, 24'h0,      0, 8'h08, 24'hA00002, 1};
        tbl[9]  = '{0, 3'd0, 24'h0,      1, 8'h00, 24'hA00002, 1};
        tbl[10] = '{0, 3'd0, 24'h0,      0, 8'h10, 24'hA00003, 1};
        tbl[11] = '{0, 3'd0, 24'h0,      1, 8'h00, 24'hA00003, 1};
        tbl[12] = '{0, 3'd0, 24'h0,      0, 8'h00, 24'hA00003, 0};

        tick();
        tick();
        reset = 1'b0;
        model_on = 1'b1;

        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_strobe[%0d]", k), 32'(d_strobe[k]), 32'h0);
            check($sformatf("rst_caddr[%0d]", k), 32'(d_caddr[k]), 32'h0);
            check($sformatf("rst_busy[%0d]", k), 32'(d_busy[k]), 32'h0);
            check($sformatf("rst_ready[%0d]", k), 32'(d_ready[k]), 32'h1);
            check($sformatf("rst_flags[%0d]", k), 32'({d_ovf[k], d_tmo[k]}), 32'h0);
        end

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].c, tbl[i].a, tbl[i].ack);
            tick();
            for (int k = 0; k < 2; k++) begin
                check($sformatf("tbl%0d_strobe[%0d]", i, k), 32'(d_strobe[k]), 32'(tbl[i].strobe));
                check($sformatf("tbl%0d_caddr[%0d]", i, k), 32'(d_caddr[k]), 32'(tbl[i].caddr));
                check($sformatf("tbl%0d_busy[%0d]", i, k), 32'(d_busy[k]), 32'(tbl[i].busy));
                check($sformatf("tbl%0d_ready[%0d]", i, k), 32'(d_ready[k]), 32'h1);
            end
        end

        // Fill: one issued + four queued, sixth push dropped; then push at full with pop.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 3'(1 + i), 24'(i), 0);
            tick();
        end
        drive(0, 3'd0, '0, 0);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("full_ovf[%0d]", k), 32'(d_ovf[k]), 32'h1);
            check($sformatf("full_ready[%0d]", k), 32'(d_ready[k]), 32'h0);
        end
        drive(0, 3'd0, '0, 1);
        tick();
        for (int k = 0; k < 2; k++)
            check($sformatf("gap_full_ready[%0d]", k), 32'(d_ready[k]), 32'h1);
        drive(1, 3'd5, 24'hABC, 0);
        tick();
        drive(0, 3'd0, '0, 0);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("refill_ready[%0d]", k), 32'(d_ready[k]), 32'h0);
            check($sformatf("refill_strobe[%0d]", k), 32'(d_strobe[k]), 32'h04);
        end
        cmdack = 1'b1;
        n = 0;
        while ((d_busy[0] || d_busy[1]) && n < 60) begin
            tick();
            n++;
        end
        cmdack = 1'b0;
        check("drain_in_budget", 32'(n < 60), 32'h1);

        // NOP pulses one cycle, gap, then load_time.
        do_reset();
        drive(1, 3'd0, 24'h7, 0);
        tick();
        drive(1, 3'd6, 24'h8, 0);
        tick();
        drive(0, 3'd0, '0, 0);
        for (int k = 0; k < 2; k++) check($sformatf("nop_pulse[%0d]", k), 32'(d_strobe[k]), 32'h01);
        tick();
        for (int k = 0; k < 2; k++) check($sformatf("nop_gap[%0d]", k), 32'(d_strobe[k]), 32'h00);
        tick();
        for (int k = 0; k < 2; k++) check($sformatf("nop_next[%0d]", k), 32'(d_strobe[k]), 32'h40);
        cmdack = 1'b1;
        tick();
        cmdack = 1'b0;
        tick();

        // Timeout: load_rfcnt never acked, writea queued behind it.
        do_reset();
        drive(1, 3'd7, 24'h9, 0);
        tick();
        drive(1, 3'd2, 24'hA, 0);
        tick();
        drive(0, 3'd0, '0, 0);
        hi_cnt = d_strobe[1][7] ? 1 : 0;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (d_strobe[1][7]) hi_cnt++;
        end
        check("to8_high_cycles", 32'(hi_cnt), 32'd9);
        check("to8_flag", 32'(d_tmo[1]), 32'h1);
        check("to8_next_issued", 32'(d_strobe[1]), 32'h04);
        check("to0_still_held", 32'(d_strobe[0]), 32'h80);
        check("to0_flag", 32'(d_tmo[0]), 32'h0);

        // Reset mid-operation with commands queued and sticky flags set.
        for (int i = 0; i < 4; i++) begin
            drive(1, 3'd3, 24'(16 + i), 0);
            tick();
        end
        drive(0, 3'd0, '0, 0);
        check("mid_ovf0_set", 32'(d_ovf[0]), 32'h1);
        reset = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("mid_rst_strobe[%0d]", k), 32'(d_strobe[k]), 32'h0);
            check($sformatf("mid_rst_busy[%0d]", k), 32'(d_busy[k]), 32'h0);
            check($sformatf("mid_rst_ready[%0d]", k), 32'(d_ready[k]), 32'h1);
            check($sformatf("mid_rst_flags[%0d]", k), 32'({d_ovf[k], d_tmo[k]}), 32'h0);
        end
        reset = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            drive(($urandom_range(0, 2) != 0), 3'($urandom), 24'($urandom),
                  ($urandom_range(0, 3) == 0));
            tick();
        end
        reset = 1'b0;
        drive(0, 3'd0, '0, 0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
